// File: rtl/pe_noc_pkg.sv
// Packet field map, packet type codes and scheduler state encoding shared by
// the PE job scheduler and its arbiter.
package pe_noc_pkg;

   localparam int PKT_W   = 39;

   localparam int TYPE_HI = 38;
   localparam int TYPE_LO = 37;
   localparam int ADDR_HI = 36;
   localparam int ADDR_LO = 29;
   localparam int ROW_HI  = 27;
   localparam int ROW_LO  = 26;
   localparam int COL_HI  = 25;
   localparam int COL_LO  = 24;
   localparam int DATA_HI = 7;
   localparam int DATA_LO = 0;

   localparam logic [1:0] PKT_JOB  = 2'b01;
   localparam logic [1:0] PKT_PSUM = 2'b10;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// around to index 0; grant is one-hot, or zero when nobody requests.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == '0 && req[i] && i >= int'(ptr)) grant[i] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (grant == '0 && req[i]) grant[i] = 1'b1;
      end
   end

endmodule

// File: rtl/pe_job_scheduler.sv
// Dispatches job packets to idle PEs round-robin, counts returning psums per
// PE, forwards them to the accumulator and supports a drain/flush sequence.
//
//   state | meaning
//   RUN   | jobs accepted and dispatched to idle PEs
//   DRAIN | no new jobs; waiting for outstanding jobs and output regs to empty
//   DONE  | drain complete (flush_done pulsed); waiting for flush to drop
module pe_job_scheduler
   import pe_noc_pkg::*;
#(
   parameter int         WIDTH        = PKT_W,
   parameter int         N_PE         = 4,
   parameter int         DEPTH_F      = 3,
   parameter logic [7:0] PE_BASE_ADDR = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [WIDTH-1:0] job_data,
   output logic             pkt_out_valid,
   input  logic             pkt_out_ready,
   output logic [WIDTH-1:0] pkt_out_data,
   input  logic             psum_valid,
   output logic             psum_ready,
   input  logic [WIDTH-1:0] psum_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [11:0]      res_data,
   output logic             res_last,
   input  logic             flush,
   output logic             flush_done,
   output logic [N_PE-1:0]  busy_vec,
   output logic             err
);

   localparam int         PW        = $clog2(N_PE);
   localparam logic [1:0] DEPTH_CNT = 2'(DEPTH_F);

   sched_state_t  state_q, state_d;
   logic [3:0]    busy_q;
   logic [1:0]    cnt_q [4];
   logic [PW-1:0] rr_q;
   logic [PW-1:0] grant_idx;
   logic [N_PE-1:0] grant_oh;
   logic          job_fire, psum_fire, psum_legal, drain_empty;
   logic [1:0]    psum_idx, psum_col, cnt_inc;
   logic          unused_in;

   // Header of incoming jobs is overwritten; psum address/pad bits are ignored.
   assign unused_in = ^{job_data[TYPE_HI:ADDR_LO], psum_data[ADDR_HI:ADDR_LO-1],
                        psum_data[COL_LO-1:DATA_HI+1]};

   assign busy_vec    = busy_q[N_PE-1:0];
   assign job_ready   = (state_q == RUN) && !(&busy_vec) && (!pkt_out_valid || pkt_out_ready);
   assign psum_ready  = !res_valid || res_ready;
   assign job_fire    = job_valid && job_ready;
   assign psum_fire   = psum_valid && psum_ready;
   assign drain_empty = (busy_vec == '0) && !pkt_out_valid && !res_valid;

   rr_arbiter #(.N(N_PE), .PW(PW)) u_arb (
      .req   (~busy_vec),
      .ptr   (rr_q),
      .grant (grant_oh)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_PE; i++) begin
         if (grant_oh[i]) grant_idx = PW'(i);
      end
   end

   assign psum_idx   = psum_data[ROW_HI:ROW_LO];
   assign psum_col   = psum_data[COL_HI:COL_LO];
   assign cnt_inc    = cnt_q[psum_idx] + 2'd1;
   assign psum_legal = (int'(psum_idx) < N_PE) && busy_q[psum_idx] &&
                       (psum_data[TYPE_HI:TYPE_LO] == PKT_PSUM) &&
                       (psum_col != 2'd0) && (psum_col <= DEPTH_CNT);

   // A granted PE is idle and a legal psum targets a busy PE, so the two
   // updates below never touch the same busy/count entry in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_out_valid <= 1'b0;
         pkt_out_data  <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_last      <= 1'b0;
         err           <= 1'b0;
         busy_q        <= '0;
         rr_q          <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         if (pkt_out_valid && pkt_out_ready) pkt_out_valid <= 1'b0;
         if (job_fire) begin
            pkt_out_valid       <= 1'b1;
            pkt_out_data        <= {PKT_JOB, PE_BASE_ADDR + 8'(grant_idx), job_data[ADDR_LO-1:0]};
            busy_q[grant_idx]   <= 1'b1;
            cnt_q[grant_idx]    <= '0;
            rr_q                <= (grant_idx == PW'(N_PE - 1)) ? '0 : grant_idx + 1'b1;
         end

         if (res_valid && res_ready) res_valid <= 1'b0;
         if (psum_fire) begin
            if (psum_legal) begin
               res_valid <= 1'b1;
               res_data  <= {psum_idx, psum_col, psum_data[DATA_HI:DATA_LO]};
               res_last  <= (cnt_inc == DEPTH_CNT);
               if (cnt_inc == DEPTH_CNT) begin
                  busy_q[psum_idx] <= 1'b0;
                  cnt_q[psum_idx]  <= '0;
               end else begin
                  cnt_q[psum_idx]  <= cnt_inc;
               end
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         RUN:   if (flush) state_d = DRAIN;
         DRAIN: begin
            if (!flush) begin
               state_d = RUN;
            end else if (drain_empty) begin
               state_d    = DONE;
               flush_done = 1'b1;
            end
         end
         DONE:  if (!flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Directed scenarios followed by a randomized phase checked against a
// behavioural model of the scheduler's dispatch/return rules.
module tb_pe_job_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid, job_ready;
   logic [38:0] job_data;
   logic        pkt_out_valid, pkt_out_ready;
   logic [38:0] pkt_out_data;
   logic        psum_valid, psum_ready;
   logic [38:0] psum_data;
   logic        res_valid, res_ready;
   logic [11:0] res_data;
   logic        res_last;
   logic        flush, flush_done;
   logic [3:0]  busy_vec;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;
   int fd_count = 0;

   pe_job_scheduler dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
      .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data),
      .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .flush(flush), .flush_done(flush_done), .busy_vec(busy_vec), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (flush_done === 1'b1) fd_count++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [38:0] mk_psum(input logic [1:0] t, input logic [1:0] row,
                                           input logic [1:0] col, input logic [7:0] v);
      return {t, 8'h00, 1'b0, row, col, 16'h0000, v};
   endfunction

   task automatic do_reset();
      reset = 1'b1; job_valid = 1'b0; psum_valid = 1'b0; flush = 1'b0;
      pkt_out_ready = 1'b1; res_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic send_job(input logic [28:0] pl);
      job_data = {2'b01, 8'h5C, pl}; job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
   endtask

   // behavioural model state for the randomized phase
   bit          m_busy [4];
   bit          pre_busy [4];
   int          m_cnt [4];
   int          m_rr;
   bit          m_pv, m_rv, m_rl, m_err;
   logic [38:0] m_pd;
   logic [11:0] m_rd;
   logic [3:0]  eb;
   int          cand [$];

   initial begin
      logic [28:0] pl, pl5;
      bit exp_jr, exp_pr, jfire, pfire, any_idle;
      int g, r, c, p;

      reset = 1'b1; job_valid = 1'b0; job_data = '0; psum_valid = 1'b0; psum_data = '0;
      pkt_out_ready = 1'b1; res_ready = 1'b1; flush = 1'b0;
      tick(); tick();
      chk("rst_pkt_valid", pkt_out_valid, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy_vec, 0);
      chk("rst_err", err, 0);
      chk("rst_flush_done", flush_done, 0);
      reset = 1'b0;
      #1;
      chk("rst_job_ready", job_ready, 1);
      chk("rst_psum_ready", psum_ready, 1);

      // single job, three psums back
      pl = 29'($urandom);
      job_data = {2'b01, 8'hAB, pl}; job_valid = 1'b1;
      #1 chk("t1_job_ready", job_ready, 1);
      tick();
      job_valid = 1'b0;
      chk("t1_pkt_valid", pkt_out_valid, 1);
      chk("t1_pkt_data", pkt_out_data, {2'b01, 8'h00, pl});
      chk("t1_busy", busy_vec, 4'b0001);
      for (int k = 1; k <= 3; k++) begin
         psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd0, 2'(k), 8'(k * 17));
         tick();
         chk("t1_res_valid", res_valid, 1);
         chk("t1_res_data", res_data, {2'd0, 2'(k), 8'(k * 17)});
         chk("t1_res_last", res_last, (k == 3) ? 1 : 0);
      end
      psum_valid = 1'b0;
      chk("t1_busy_free", busy_vec, 4'b0000);
      chk("t1_pkt_drained", pkt_out_valid, 0);
      tick();
      chk("t1_res_idle", res_valid, 0);

      // five jobs into four PEs
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pl = 29'($urandom);
         job_data = {2'b01, 8'hFF, pl}; job_valid = 1'b1;
         #1 chk("t2_job_ready", job_ready, 1);
         tick();
         chk("t2_pkt_valid", pkt_out_valid, 1);
         chk("t2_pkt_data", pkt_out_data, {2'b01, 8'(k), pl});
      end
      chk("t2_busy_full", busy_vec, 4'b1111);
      pl5 = 29'($urandom);
      job_data = {2'b01, 8'h00, pl5}; job_valid = 1'b1;
      #1 chk("t2_job_blocked", job_ready, 0);
      for (int k = 0; k < 3; k++) begin
         c = (k == 0) ? 3 : k;
         psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd2, 2'(c), 8'(8'h40 + c));
         #1 chk("t2_job_still_blocked", job_ready, 0);
         tick();
         chk("t2_res_data", res_data, {2'd2, 2'(c), 8'(8'h40 + c)});
         chk("t2_res_last", res_last, (k == 2) ? 1 : 0);
      end
      psum_valid = 1'b0;
      #1;
      chk("t2_busy_freed", busy_vec, 4'b1011);
      chk("t2_job_ready_again", job_ready, 1);
      tick();
      job_valid = 1'b0;
      chk("t2_fifth_pkt", pkt_out_data, {2'b01, 8'h02, pl5});
      chk("t2_busy_full2", busy_vec, 4'b1111);

      // illegal psums
      do_reset();
      send_job(29'($urandom));
      psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd2, 2'd1, 8'h11);
      tick();
      psum_valid = 1'b0;
      chk("t3_idle_pe_res", res_valid, 0);
      chk("t3_idle_pe_err", err, 1);
      chk("t3_idle_pe_busy", busy_vec, 4'b0001);
      do_reset();
      chk("t3_err_cleared", err, 0);
      send_job(29'($urandom));
      psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd0, 2'd0, 8'h22);
      tick();
      chk("t3_col0_res", res_valid, 0);
      chk("t3_col0_err", err, 1);
      psum_data = mk_psum(2'b01, 2'd0, 2'd1, 8'h23);
      tick();
      chk("t3_type_res", res_valid, 0);
      for (int k = 1; k <= 3; k++) begin
         psum_data = mk_psum(2'b10, 2'd0, 2'(k), 8'(k));
         tick();
         chk("t3_count_unchanged", res_last, (k == 3) ? 1 : 0);
      end
      psum_valid = 1'b0;
      chk("t3_busy_after", busy_vec, 4'b0000);

      // accumulator backpressure
      do_reset();
      send_job(29'($urandom));
      res_ready = 1'b0;
      psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd0, 2'd1, 8'h5A);
      tick();
      chk("t4_res_valid", res_valid, 1);
      chk("t4_res_data", res_data, 12'h15A);
      psum_data = mk_psum(2'b10, 2'd0, 2'd2, 8'hC3);
      for (int k = 0; k < 2; k++) begin
         #1 chk("t4_psum_blocked", psum_ready, 0);
         tick();
         chk("t4_res_held", res_data, 12'h15A);
         chk("t4_res_valid_held", res_valid, 1);
      end
      res_ready = 1'b1;
      #1 chk("t4_psum_ready", psum_ready, 1);
      tick();
      psum_valid = 1'b0;
      chk("t4_res_next", res_data, 12'h2C3);
      chk("t4_res_last", res_last, 0);
      tick();
      chk("t4_res_idle", res_valid, 0);

      // flush with two busy PEs
      do_reset();
      send_job(29'($urandom));
      send_job(29'($urandom));
      chk("t5_busy", busy_vec, 4'b0011);
      flush = 1'b1;
      tick();
      job_valid = 1'b1; job_data = {2'b01, 8'h00, 29'h1};
      #1 chk("t5_job_blocked", job_ready, 0);
      fd_count = 0;
      for (int pe = 0; pe < 2; pe++) begin
         for (int k = 1; k <= 3; k++) begin
            psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'(pe), 2'(k), 8'(pe * 16 + k));
            #1 chk("t5_no_done_early", flush_done, 0);
            tick();
         end
      end
      psum_valid = 1'b0;
      #1 chk("t5_done_wait_res", flush_done, 0);
      chk("t5_job_blocked2", job_ready, 0);
      tick();
      chk("t5_done_pulse", flush_done, 1);
      tick();
      chk("t5_done_once", flush_done, 0);
      tick();
      chk("t5_done_count", fd_count, 1);
      chk("t5_no_issue", pkt_out_valid, 0);
      flush = 1'b0;
      tick();
      chk("t5_run_again", job_ready, 1);
      job_valid = 1'b0;

      // reset in the middle of a job
      do_reset();
      send_job(29'($urandom));
      psum_valid = 1'b1; psum_data = mk_psum(2'b10, 2'd3, 2'd1, 8'h01);
      tick();
      res_ready = 1'b0; psum_data = mk_psum(2'b10, 2'd0, 2'd1, 8'h02);
      tick();
      psum_valid = 1'b0;
      pkt_out_ready = 1'b0; job_valid = 1'b1; job_data = {2'b01, 8'h00, 29'h7};
      tick();
      job_valid = 1'b0;
      chk("t6_pre_err", err, 1);
      chk("t6_pre_res", res_valid, 1);
      chk("t6_pre_pkt", pkt_out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", busy_vec, 0);
      chk("t6_pkt_valid", pkt_out_valid, 0);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_err", err, 0);

      // randomized dispatch / return against the model
      do_reset();
      for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_cnt[i] = 0; end
      m_rr = 0; m_pv = 0; m_rv = 0; m_rl = 0; m_err = 0; m_pd = '0; m_rd = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!job_valid && ($urandom % 3 == 0)) begin
            job_valid = 1'b1; job_data = {2'b01, 8'($urandom), 29'($urandom)};
         end
         if (!psum_valid && ($urandom % 2 == 0)) begin
            cand.delete();
            for (int i = 0; i < 4; i++) if (m_busy[i]) cand.push_back(i);
            if ($urandom % 25 == 0) begin
               psum_valid = 1'b1;
               psum_data = mk_psum(2'b10, 2'($urandom_range(0, 3)), 2'd0, 8'($urandom));
            end else if (cand.size() > 0) begin
               p = cand[$urandom_range(0, cand.size() - 1)];
               psum_valid = 1'b1;
               psum_data = mk_psum(2'b10, 2'(p), 2'($urandom_range(1, 3)), 8'($urandom));
            end
         end
         pkt_out_ready = ($urandom % 4 != 0);
         res_ready     = ($urandom % 3 != 0);
         #1;
         any_idle = 0;
         for (int i = 0; i < 4; i++) begin
            if (!m_busy[i]) any_idle = 1;
            eb[i] = m_busy[i];
         end
         exp_jr = any_idle && (!m_pv || pkt_out_ready);
         exp_pr = !m_rv || res_ready;
         chk("rnd_job_ready", job_ready, exp_jr);
         chk("rnd_psum_ready", psum_ready, exp_pr);
         chk("rnd_pkt_valid", pkt_out_valid, m_pv);
         if (m_pv) chk("rnd_pkt_data", pkt_out_data, m_pd);
         chk("rnd_res_valid", res_valid, m_rv);
         if (m_rv) begin
            chk("rnd_res_data", res_data, m_rd);
            chk("rnd_res_last", res_last, m_rl);
         end
         chk("rnd_busy", busy_vec, eb);
         chk("rnd_err", err, m_err);

         jfire = job_valid && exp_jr;
         pfire = psum_valid && exp_pr;
         pre_busy = m_busy;
         if (m_pv && pkt_out_ready) m_pv = 0;
         if (jfire) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && !pre_busy[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
            m_pv = 1;
            m_pd = {2'b01, 8'(g), job_data[28:0]};
            m_busy[g] = 1; m_cnt[g] = 0;
            m_rr = (g + 1) % 4;
         end
         if (m_rv && res_ready) m_rv = 0;
         if (pfire) begin
            r = int'(psum_data[27:26]);
            c = int'(psum_data[25:24]);
            if (pre_busy[r] && psum_data[38:37] == 2'b10 && c >= 1 && c <= 3) begin
               m_cnt[r] = m_cnt[r] + 1;
               m_rv = 1;
               m_rd = {2'(r), 2'(c), psum_data[7:0]};
               m_rl = (m_cnt[r] == 3);
               if (m_rl) begin m_busy[r] = 0; m_cnt[r] = 0; end
            end else begin
               m_err = 1;
            end
         end
         tick();
         if (jfire) job_valid = 1'b0;
         if (pfire) psum_valid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
